// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops a word from the TX FIFO and frames it as start, LSB-first data, [parity], stop.
// Latency: tx_out drops to the start bit the cycle after the pop edge; frame = (1+DATA_BITS+[1]+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: pops only when tx_enable & ~fifo_empty, in IDLE or on the last STOP cycle (zero-gap back-to-back frames).
// Optional parity bit is built in when the macro UART_TX_PARITY_EN is defined (adds input parity_odd).
module uart_tx_serializer #(
    parameter int DATA_BITS    = 8,   // must match the FIFO word width
    parameter int CLKS_PER_BIT = 16,  // minimum 2
    parameter int STOP_BITS    = 1    // 1 or 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic                 fifo_empty,
    input  logic                 tx_enable,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 r_enable,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [TMR_W-1:0]     r_timer;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_tx_out;

    logic [2:0]           w_nxt_state;
    logic [TMR_W-1:0]     w_nxt_timer;
    logic [IDX_W-1:0]     w_nxt_idx;
    logic [DATA_BITS-1:0] w_nxt_shreg;
    logic                 w_nxt_tx;
    logic                 w_pop_ok;
    logic                 w_tc;
    logic                 w_last_stop;

`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
    logic                 w_nxt_parity;
`endif

    assign w_pop_ok    = tx_enable & ~fifo_empty;
    assign w_tc        = (r_timer == TMR_LAST);
    assign w_last_stop = (r_state == ST_STOP) & w_tc & (r_idx == STOP_LAST);

    // The pop strobe is gated by reset so a held reset can never advance the FIFO read pointer.
    assign r_enable   = n_rst & w_pop_ok & ((r_state == ST_IDLE) | w_last_stop);
    assign frame_done = w_last_stop;
    assign tx_busy    = (r_state != ST_IDLE);
    assign tx_out     = r_tx_out;

    // Next-state, bit-timer, bit-index and shift-register update; a pop overrides whatever the state would do.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_timer = r_timer;
        w_nxt_idx   = r_idx;
        w_nxt_shreg = r_shreg;
`ifdef UART_TX_PARITY_EN
        w_nxt_parity = r_parity;
`endif
        case (r_state)
            ST_START: begin
                if (w_tc) begin
                    w_nxt_state = ST_DATA;
                    w_nxt_timer = '0;
                    w_nxt_idx   = '0;
                end else begin
                    w_nxt_timer = r_timer + TMR_W'(1);
                end
            end
            ST_DATA: begin
                if (w_tc) begin
                    w_nxt_timer = '0;
                    w_nxt_shreg = r_shreg >> 1;
                    if (r_idx == DATA_LAST) begin
                        w_nxt_idx = '0;
`ifdef UART_TX_PARITY_EN
                        w_nxt_state = ST_PARITY;
`else
                        w_nxt_state = ST_STOP;
`endif
                    end else begin
                        w_nxt_idx = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_nxt_timer = r_timer + TMR_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tc) begin
                    w_nxt_state = ST_STOP;
                    w_nxt_timer = '0;
                    w_nxt_idx   = '0;
                end else begin
                    w_nxt_timer = r_timer + TMR_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (w_tc) begin
                    w_nxt_timer = '0;
                    if (r_idx == STOP_LAST) begin
                        w_nxt_idx   = '0;
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_idx = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_nxt_timer = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_timer = '0;
                w_nxt_idx   = '0;
            end
        endcase

        if (r_enable) begin
            w_nxt_state = ST_START;
            w_nxt_timer = '0;
            w_nxt_idx   = '0;
            w_nxt_shreg = fifo_data;
`ifdef UART_TX_PARITY_EN
            w_nxt_parity = (^fifo_data) ^ parity_odd;
`endif
        end
    end

    // Line level is derived from the state being entered so tx_out is a clean register output.
    always_comb begin
        w_nxt_tx = 1'b1;
        case (w_nxt_state)
            ST_START:  w_nxt_tx = 1'b0;
            ST_DATA:   w_nxt_tx = w_nxt_shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_nxt_tx = w_nxt_parity;
`endif
            default:   w_nxt_tx = 1'b1;
        endcase
    end

    // State registers; reset abandons any frame and returns the line high immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_idx    <= '0;
            r_shreg  <= '0;
            r_tx_out <= 1'b1;
        end else begin
            r_state  <= w_nxt_state;
            r_timer  <= w_nxt_timer;
            r_idx    <= w_nxt_idx;
            r_shreg  <= w_nxt_shreg;
            r_tx_out <= w_nxt_tx;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity bit captured together with the data word on the pop edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_nxt_parity;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer at CLKS_PER_BIT=4, STOP_BITS=1.
// Stimulus pushes FIFO words and their hand-written expected line frames; a negedge monitor checks every cycle.
// Parity scenarios are included when UART_TX_PARITY_EN is defined.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    // start, data LSB first, parity (even for these words), stop
    localparam logic [0:10] F_A5 = 11'b01010010101;
    localparam logic [0:10] F_00 = 11'b00000000001;
    localparam logic [0:10] F_FF = 11'b01111111101;
    localparam logic [0:10] F_3C = 11'b00011110001;
    localparam logic [0:10] F_07E = 11'b01110000011;
    localparam logic [0:10] F_07O = 11'b01110000001;
`else
    localparam int NB = 10;
    // start, data LSB first, stop; last position unused
    localparam logic [0:10] F_A5 = 11'b01010010110;
    localparam logic [0:10] F_00 = 11'b00000000010;
    localparam logic [0:10] F_FF = 11'b01111111110;
    localparam logic [0:10] F_3C = 11'b00011110010;
`endif

    typedef struct packed {
        logic tx;
        logic done;
        logic pop;
    } exp_t;

    logic       clk = 1'b0;
    bit         clk_run = 1'b0;
    logic       n_rst = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       tx_enable = 1'b0;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd = 1'b0;
`endif
    logic       r_enable;
    logic       tx_out;
    logic       tx_busy;
    logic       frame_done;

    int         n_checks = 0;
    int         n_errors = 0;
    int         pop_cnt = 0;
    bit         mon_en = 1'b0;
    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    uart_tx_serializer #(
        .DATA_BITS   (8),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (1)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .tx_enable (tx_enable),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .r_enable  (r_enable),
        .tx_out    (tx_out),
        .tx_busy   (tx_busy),
        .frame_done(frame_done)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand a hand-written frame into per-cycle expectations.
    task automatic push_frame(input logic [0:10] bits, input bit next_pop);
        exp_t e;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                e.tx   = bits[b];
                e.done = (b == NB - 1) && (c == CPB - 1);
                e.pop  = e.done & next_pop;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, (n < 400) ? 1 : 0, 1);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_busy_end"}, tx_busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor and FIFO model: checks every cycle, applies pops after the edge that took them.
    initial begin : monitor
        exp_t e;
        bit   pend;
        forever begin
            @(negedge clk);
            pend = r_enable;
            if (r_enable) pop_cnt++;
            if (mon_en) begin
                if (tx_busy) begin
                    if (exp_q.size() == 0) begin
                        check("busy_without_frame", tx_busy, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_out", tx_out, e.tx);
                        check("frame_done", frame_done, e.done);
                        check("r_enable_busy", r_enable, e.pop);
                    end
                end else begin
                    check("idle_tx_out", tx_out, 1);
                    check("idle_frame_done", frame_done, 0);
                    check("idle_r_enable", r_enable, tx_enable & ~fifo_empty);
                end
            end
            @(posedge clk);
            #1;
            if (pend) begin
                check("pop_nonempty", (fifo_q.size() != 0) ? 1 : 0, 1);
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            #1;
            fifo_empty = (fifo_q.size() == 0);
            fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
    end

    initial begin : stimulus
        int n;
        // Async reset with the clock stopped
        #2 n_rst = 1'b0;
        tx_enable = 1'b1;
        #1;
        check("rst_tx_out", tx_out, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_r_enable", r_enable, 0);
        check("rst_frame_done", frame_done, 0);
        #2 n_rst = 1'b1;
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Single word 0xA5
        pop_cnt = 0;
        fifo_q.push_back(8'hA5);
        push_frame(F_A5, 1'b0);
        wait_idle("t1");
        check("t1_pops", pop_cnt, 1);

        // Back-to-back 0x00 then 0xFF with no idle gap
        pop_cnt = 0;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        push_frame(F_00, 1'b1);
        push_frame(F_FF, 1'b0);
        wait_idle("t2");
        check("t2_pops", pop_cnt, 2);

        // Empty FIFO for 100 cycles
        pop_cnt = 0;
        repeat (100) @(posedge clk);
        #1;
        check("t3_pops", pop_cnt, 0);
        check("t3_tx_out", tx_out, 1);

        // Drop tx_enable during DATA of frame 1
        pop_cnt = 0;
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h81);
        push_frame(F_3C, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        tx_enable = 1'b0;
        wait_idle("t4");
        check("t4_pops", pop_cnt, 1);
        check("t4_fifo_left", fifo_q.size(), 1);
        fifo_q.delete();
        repeat (2) @(posedge clk);
        #1;

        // Reset during START: line returns high at once, no pop while in reset
        mon_en = 1'b0;
        tx_enable = 1'b1;
        pop_cnt = 0;
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h81);
        repeat (3) @(posedge clk);
        #3;
        check("t5_pre_rst_tx", tx_out, 0);
        n_rst = 1'b0;
        #1;
        check("t5_rst_tx_out", tx_out, 1);
        check("t5_rst_busy", tx_busy, 0);
        check("t5_rst_r_enable", r_enable, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_pops", pop_cnt, 1);
        tx_enable = 1'b0;
        n_rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
        // Parity frames for 0x07: even -> 1, odd -> 0
        tx_enable = 1'b1;
        pop_cnt = 0;
        parity_odd = 1'b0;
        fifo_q.push_back(8'h07);
        push_frame(F_07E, 1'b0);
        wait_idle("t6e");
        parity_odd = 1'b1;
        fifo_q.push_back(8'h07);
        push_frame(F_07O, 1'b0);
        wait_idle("t6o");
        check("t6_pops", pop_cnt, 2);

        // Reset during PARITY (odd parity -> line low before reset)
        mon_en = 1'b0;
        fifo_q.push_back(8'h07);
        n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t7_start_timeout", (n < 20) ? 1 : 0, 1);
        repeat (37) @(negedge clk);
        check("t7_parity_bit", tx_out, 0);
        n_rst = 1'b0;
        #1;
        check("t7_rst_tx_out", tx_out, 1);
        check("t7_rst_busy", tx_busy, 0);
        @(posedge clk);
        #1;
        tx_enable = 1'b0;
        n_rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
`endif

        n = n + 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
